bram_wb8_vga_dp: RTL and testbench

BRAM_WB8_VGA_DP -- requirements
Module: bram_wb8_vga_dp

---
 rtl/bram_pkg.sv | 13 +
 rtl/bram_sp8.sv | 19 +
 rtl/bram_wb8_vga_dp.sv | 80 ++++++++
 tb/tb_bram_wb8_vga_dp.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared sizes and the RAM request bundle for the 8 KiB Wishbone/video block RAM.
package bram_pkg;
  localparam int RAM_ADR_WIDTH = 13;
  localparam int RAM_DAT_WIDTH = 8;
  localparam int RAM_DEPTH     = 8192;

  typedef struct packed {
    logic                     en;
    logic                     we;
    logic [RAM_ADR_WIDTH-1:0] adr;
    logic [RAM_DAT_WIDTH-1:0] dat;
  } ram_req_t;
endpackage

// File: rtl/bram_sp8.sv
// Single-port synchronous 8192x8 RAM, written to map onto block RAM (no reset on array or output).
module bram_sp8
  import bram_pkg::*;
#(
  parameter string RAMINITFILE = "./ram/raminit.dat"
) (
  input  logic                     clk,
  input  ram_req_t                 req,
  output logic [RAM_DAT_WIDTH-1:0] q
);
  logic [RAM_DAT_WIDTH-1:0] mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (req.en) begin
      if (req.we) mem[req.adr] <= req.dat;
      else        q <= mem[req.adr];
    end
  end
endmodule

// File: rtl/bram_wb8_vga_dp.sv
// Wishbone (pipelined) byte RAM sharing one physical port with a priority video read port.
// Video port enabled by defining BRAM_VGA_PORT_EN; otherwise stall and video data are tied 0.
module bram_wb8_vga_dp
  import bram_pkg::*;
#(
  parameter string RAMINITFILE = "./ram/raminit.dat"
) (
  input  logic                     I_wb_clk,
  input  logic                     I_reset_n,
  input  logic                     I_wb_stb,
  input  logic                     I_wb_we,
  input  logic [RAM_ADR_WIDTH-1:0] I_wb_adr,
  input  logic [RAM_DAT_WIDTH-1:0] I_wb_dat,
  output logic [RAM_DAT_WIDTH-1:0] O_wb_dat,
  output logic                     O_wb_ack,
  output logic                     O_wb_stall,
  input  logic                     I_vga_req,
  input  logic [RAM_ADR_WIDTH-1:0] I_vga_adr,
  output logic [RAM_DAT_WIDTH-1:0] O_vga_dat
);
  ram_req_t                 req;
  logic [RAM_DAT_WIDTH-1:0] ram_q;
  logic                     vga_take, wb_take;
  logic                     wb_rd_q, vga_rd_q;
  logic [RAM_DAT_WIDTH-1:0] wb_hold, vga_hold;

`ifdef BRAM_VGA_PORT_EN
  assign vga_take = I_vga_req;
`else
  logic unused_vga;
  assign unused_vga = ^{I_vga_req, I_vga_adr};
  assign vga_take   = 1'b0;
`endif

  assign O_wb_stall = vga_take;
  assign wb_take    = I_wb_stb & ~vga_take;

  // Port arbitration; nothing reaches the RAM while reset is held.
  always_comb begin
    req = '0;
    if (I_reset_n) begin
      if (vga_take) begin
        req.en  = 1'b1;
        req.adr = I_vga_adr;
      end else if (wb_take) begin
        req.en  = 1'b1;
        req.we  = I_wb_we;
        req.adr = I_wb_adr;
        req.dat = I_wb_dat;
      end
    end
  end

  bram_sp8 #(.RAMINITFILE(RAMINITFILE)) u_ram (
    .clk (I_wb_clk),
    .req (req),
    .q   (ram_q)
  );

  // The RAM output register has no reset, so each side sees it only in the cycle
  // after its own read and otherwise a reset-able copy of its last result.
  always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      O_wb_ack <= 1'b0;
      wb_rd_q  <= 1'b0;
      vga_rd_q <= 1'b0;
      wb_hold  <= '0;
      vga_hold <= '0;
    end else begin
      O_wb_ack <= wb_take;
      wb_rd_q  <= wb_take & ~I_wb_we;
      vga_rd_q <= vga_take;
      if (wb_rd_q)  wb_hold  <= ram_q;
      if (vga_rd_q) vga_hold <= ram_q;
    end
  end

  assign O_wb_dat  = wb_rd_q  ? ram_q : wb_hold;
  assign O_vga_dat = vga_rd_q ? ram_q : vga_hold;
endmodule

// File: tb/tb_bram_wb8_vga_dp.sv
// Randomised self-checking bench for bram_wb8_vga_dp against an array-based memory model.
module tb_bram_wb8_vga_dp;
`ifdef BRAM_VGA_PORT_EN
  localparam bit VGA_EN = 1'b1;
`else
  localparam bit VGA_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb, we, vga_req;
  logic [12:0] adr, vga_adr;
  logic [7:0]  wdat, wb_dat, vga_dat;
  logic        ack, stall;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] model [8192];
  bit         known [8192];
  logic [7:0] exp_wb, exp_vga;
  bit         exp_wb_known, exp_vga_known;

  always #5 clk = ~clk;

  bram_wb8_vga_dp #(.RAMINITFILE("")) dut (
    .I_wb_clk  (clk),
    .I_reset_n (rst_n),
    .I_wb_stb  (stb),
    .I_wb_we   (we),
    .I_wb_adr  (adr),
    .I_wb_dat  (wdat),
    .O_wb_dat  (wb_dat),
    .O_wb_ack  (ack),
    .O_wb_stall(stall),
    .I_vga_req (vga_req),
    .I_vga_adr (vga_adr),
    .O_vga_dat (vga_dat)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input bit w, input logic [12:0] a, input logic [7:0] d,
                       input bit vr, input logic [12:0] va);
    stb = s; we = w; adr = a; wdat = d; vga_req = vr; vga_adr = va;
  endtask

  task automatic idle();
    drive(0, 0, 13'h0, 8'h00, 0, 13'h0);
  endtask

  // Preload through the Wishbone side since the bench builds with no init file.
  task automatic wb_write(input logic [12:0] a, input logic [7:0] d);
    drive(1, 1, a, d, 0, 13'h0);
    step();
    model[a] = d; known[a] = 1'b1;
    n_cmp++;
    if (ack !== 1'b1) begin n_err++; $display("FAIL preload_ack adr=%h got %b want 1", a, ack); end
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 1, 13'h0005, 8'hEE, 1, 13'h0005);
    step(); step();
    n_cmp += 4;
    if (ack !== 1'b0)        begin n_err++; $display("FAIL reset_ack got %b want 0", ack); end
    if (wb_dat !== 8'h00)    begin n_err++; $display("FAIL reset_wb_dat got %h want 00", wb_dat); end
    if (vga_dat !== 8'h00)   begin n_err++; $display("FAIL reset_vga_dat got %h want 00", vga_dat); end
    if (stall !== VGA_EN)    begin n_err++; $display("FAIL reset_stall got %b want %b", stall, VGA_EN); end
    idle();
    rst_n = 1'b1;
    step();
    exp_wb = 8'h00; exp_wb_known = 1; exp_vga = 8'h00; exp_vga_known = 1;
  endtask

  task automatic test_read_path();
    wb_write(13'h0010, 8'hA5);
    drive(1, 0, 13'h0010, 8'h00, 0, 13'h0);
    step();
    idle();
    n_cmp += 2;
    if (ack !== 1'b1)     begin n_err++; $display("FAIL read_ack got %b want 1", ack); end
    if (wb_dat !== 8'hA5) begin n_err++; $display("FAIL read_dat got %h want a5", wb_dat); end
    step();
    n_cmp += 2;
    if (ack !== 1'b0)     begin n_err++; $display("FAIL read_ack_drop got %b want 0", ack); end
    if (wb_dat !== 8'hA5) begin n_err++; $display("FAIL read_dat_hold got %h want a5", wb_dat); end
  endtask

  task automatic test_write_read();
    drive(1, 1, 13'h1FFF, 8'h3C, 0, 13'h0);
    step();
    model[13'h1FFF] = 8'h3C; known[13'h1FFF] = 1'b1;
    n_cmp += 2;
    if (ack !== 1'b1)     begin n_err++; $display("FAIL wr_ack got %b want 1", ack); end
    if (wb_dat !== 8'hA5) begin n_err++; $display("FAIL wr_dat_unchanged got %h want a5", wb_dat); end
    drive(1, 0, 13'h1FFF, 8'h00, 0, 13'h0);
    step();
    idle();
    n_cmp += 2;
    if (ack !== 1'b1)     begin n_err++; $display("FAIL rd_after_wr_ack got %b want 1", ack); end
    if (wb_dat !== 8'h3C) begin n_err++; $display("FAIL rd_after_wr_dat got %h want 3c", wb_dat); end
  endtask

  task automatic test_stall();
    logic [7:0] want;
    wb_write(13'h0020, 8'h11);
    drive(1, 1, 13'h0020, 8'h77, 1, 13'h0040);
    #1;
    n_cmp++;
    if (stall !== VGA_EN) begin n_err++; $display("FAIL stall_flag got %b want %b", stall, VGA_EN); end
    step();
    n_cmp++;
    if (ack !== !VGA_EN)  begin n_err++; $display("FAIL stall_ack got %b want %b", ack, !VGA_EN); end
    if (!VGA_EN) model[13'h0020] = 8'h77;
    drive(1, 0, 13'h0020, 8'h00, 0, 13'h0);
    step();
    n_cmp++;
    if (wb_dat !== model[13'h0020]) begin
      n_err++; $display("FAIL stall_mem_kept got %h want %h", wb_dat, model[13'h0020]);
    end
    drive(1, 1, 13'h0020, 8'h77, 0, 13'h0);
    step();
    model[13'h0020] = 8'h77;
    n_cmp++;
    if (ack !== 1'b1) begin n_err++; $display("FAIL retry_ack got %b want 1", ack); end
    drive(1, 0, 13'h0020, 8'h00, 0, 13'h0);
    step();
    want = 8'h77;
    n_cmp++;
    if (wb_dat !== want) begin n_err++; $display("FAIL retry_mem got %h want %h", wb_dat, want); end
    idle();
    exp_wb = want; exp_wb_known = 1;
  endtask

  task automatic test_vga_read();
    logic [7:0] want;
    wb_write(13'h0100, 8'h5A);
    drive(0, 0, 13'h0, 8'h00, 1, 13'h0100);
    step();
    want = VGA_EN ? 8'h5A : 8'h00;
    n_cmp++;
    if (vga_dat !== want) begin n_err++; $display("FAIL vga_read got %h want %h", vga_dat, want); end
    idle();
    step();
    n_cmp++;
    if (vga_dat !== want) begin n_err++; $display("FAIL vga_hold got %h want %h", vga_dat, want); end
    exp_vga = want; exp_vga_known = 1;
  endtask

  task automatic test_random();
    int n_acc = 0, n_ack = 0;
    bit s, w, vr, acc;
    logic [12:0] a, va;
    logic [7:0] d;
    for (int i = 0; i < 64; i++) wb_write(13'h1F00 + 13'(i), 8'($urandom));
    for (int i = 0; i < 400; i++) begin
      s  = ($urandom_range(0, 3) != 0);
      w  = $urandom_range(0, 1);
      a  = 13'h1F00 + 13'($urandom_range(0, 63));
      d  = 8'($urandom);
      vr = (i % 4 == 3);
      va = 13'h1F00 + 13'($urandom_range(0, 63));
      drive(s, w, a, d, vr, va);
      #1;
      n_cmp++;
      if (stall !== (VGA_EN && vr)) begin
        n_err++; $display("FAIL rnd_stall i=%0d got %b want %b", i, stall, VGA_EN && vr);
      end
      acc = s && !(VGA_EN && vr);
      if (VGA_EN && vr) begin exp_vga = model[va]; exp_vga_known = known[va]; end
      if (acc) begin
        n_acc++;
        if (w) begin model[a] = d; known[a] = 1'b1; end
        else begin exp_wb = model[a]; exp_wb_known = known[a]; end
      end
      step();
      if (ack === 1'b1) n_ack++;
      n_cmp++;
      if (ack !== acc) begin n_err++; $display("FAIL rnd_ack i=%0d got %b want %b", i, ack, acc); end
      if (exp_wb_known) begin
        n_cmp++;
        if (wb_dat !== exp_wb) begin
          n_err++; $display("FAIL rnd_wb_dat i=%0d got %h want %h", i, wb_dat, exp_wb);
        end
      end
      if (exp_vga_known) begin
        n_cmp++;
        if (vga_dat !== exp_vga) begin
          n_err++; $display("FAIL rnd_vga_dat i=%0d got %h want %h", i, vga_dat, exp_vga);
        end
      end
    end
    idle();
    n_cmp++;
    if (n_ack != n_acc) begin n_err++; $display("FAIL rnd_ack_count got %0d want %0d", n_ack, n_acc); end
  endtask

  task automatic test_reset_mid();
    wb_write(13'h1234, 8'h9E);
    drive(1, 0, 13'h1234, 8'h00, 0, 13'h0);
    step();
    n_cmp++;
    if (ack !== 1'b1) begin n_err++; $display("FAIL mid_pre_ack got %b want 1", ack); end
    drive(1, 1, 13'h1234, 8'h00, 0, 13'h0);
    rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if (ack !== 1'b0)      begin n_err++; $display("FAIL mid_ack got %b want 0", ack); end
    if (wb_dat !== 8'h00)  begin n_err++; $display("FAIL mid_wb_dat got %h want 00", wb_dat); end
    if (vga_dat !== 8'h00) begin n_err++; $display("FAIL mid_vga_dat got %h want 00", vga_dat); end
    step(); step();
    idle();
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (ack !== 1'b0) begin n_err++; $display("FAIL mid_release_ack got %b want 0", ack); end
    drive(1, 0, 13'h1234, 8'h00, 0, 13'h0);
    step();
    idle();
    n_cmp += 2;
    if (ack !== 1'b1)     begin n_err++; $display("FAIL mid_after_ack got %b want 1", ack); end
    if (wb_dat !== 8'h9E) begin n_err++; $display("FAIL mid_after_dat got %h want 9e", wb_dat); end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin model[i] = 8'h00; known[i] = 1'b0; end
    exp_wb = 8'h00; exp_vga = 8'h00; exp_wb_known = 0; exp_vga_known = 0;
    idle();
    test_reset();
    test_read_path();
    test_write_read();
    test_stall();
    test_vga_read();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
